// File: rtl/i2c_wr_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_wr_arbiter
// Shares one open-drain serial write line between two register-write clients.
// Each accepted request becomes one frame, sent one bit per clk:
//   START, {saddr,1'b0} + ACK, raddr + ACK, data + ACK, STOP, then GAP_CYCLES
//   idle cycles with the line released.
// Requesters are served round-robin.
//
// Handshake: a requester raises reqN_valid and holds it and its payload
// stable until reqN_ready. reqN_ready is a single-cycle pulse that only
// occurs in IDLE. The payload is captured on that cycle, so later changes
// have no effect on the frame. Nothing is granted while reset is asserted.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   reqN_valid        requester N has a write pending (N = 0, 1)
//   reqN_ready        1-cycle pulse: requester N payload accepted
//   reqN_saddr/raddr/data   7-bit slave address, 8-bit register address, data
//   busy              frame in progress (state other than IDLE)
//   done              1-cycle pulse in the STOP cycle
//   done_id           owner of the finished frame (valid with done)
//   nack              valid with done: frame was aborted on a NACK
//   sda               open-drain serial data (driven low or released)
//   dbg_state         current FSM state (IDLE encodes as 0)
// -----------------------------------------------------------------------------
module i2c_wr_arbiter #(
  parameter int GAP_CYCLES = 2,     // 1..15
  parameter bit ACK_CHECK  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [6:0] req0_saddr,
  input  logic [7:0] req0_raddr,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [6:0] req1_saddr,
  input  logic [7:0] req1_raddr,
  input  logic [7:0] req1_data,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic       nack,
  inout  wire        sda,
  output logic [3:0] dbg_state
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_SADDR = 4'd2;
  localparam logic [3:0] S_ACK1  = 4'd3;
  localparam logic [3:0] S_RADDR = 4'd4;
  localparam logic [3:0] S_ACK2  = 4'd5;
  localparam logic [3:0] S_DATA  = 4'd6;
  localparam logic [3:0] S_ACK3  = 4'd7;
  localparam logic [3:0] S_STOP  = 4'd8;
  localparam logic [3:0] S_GAP   = 4'd9;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic [3:0] r_state;
  logic [2:0] r_cnt;
  logic [3:0] r_gap;
  logic [7:0] r_saddr;
  logic [7:0] r_raddr;
  logic [7:0] r_data;
  logic       r_owner;
  logic       r_last_grant;
  logic       r_nack;

  logic w_grant;
  logic w_winner;
  logic w_bit;
  logic w_sda_oe;
  logic w_ack_fail;

  // Grant decision. With both valid, the requester that did not win last
  // time goes; otherwise whichever is valid goes.
  always_comb begin
    w_grant = (r_state == S_IDLE) && !rst && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) begin
      w_winner = ~r_last_grant;
    end else begin
      w_winner = req1_valid;
    end
  end

  assign req0_ready = w_grant && !w_winner;
  assign req1_ready = w_grant &&  w_winner;

  // Bit currently on the wire. Anything that is not a data bit or START
  // reads as 1, i.e. the line is released.
  always_comb begin
    w_bit = 1'b1;
    case (r_state)
      S_START: w_bit = 1'b0;
      S_SADDR: w_bit = r_saddr[r_cnt];
      S_RADDR: w_bit = r_raddr[r_cnt];
      S_DATA:  w_bit = r_data[r_cnt];
      default: w_bit = 1'b1;
    endcase
  end

  assign w_sda_oe = ~w_bit;
  assign sda      = w_sda_oe ? 1'b0 : 1'bz;

  // A released ACK slot that still reads high means nobody acknowledged.
  assign w_ack_fail = ACK_CHECK && (sda == 1'b1);

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_STOP);
  assign done_id   = r_owner;
  assign nack      = r_nack;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd7;
      r_gap        <= 4'd0;
      r_saddr      <= 8'd0;
      r_raddr      <= 8'd0;
      r_data       <= 8'd0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;   // requester 0 wins the first contest
      r_nack       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            if (w_winner) begin
              r_saddr <= {req1_saddr, 1'b0};
              r_raddr <= req1_raddr;
              r_data  <= req1_data;
            end else begin
              r_saddr <= {req0_saddr, 1'b0};
              r_raddr <= req0_raddr;
              r_data  <= req0_data;
            end
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= 3'd7;
          r_state <= S_SADDR;
        end
        S_SADDR: begin
          if (r_cnt == 3'd0) r_state <= S_ACK1;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        S_ACK1: begin
          if (w_ack_fail) begin
            r_nack  <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt   <= 3'd7;
            r_state <= S_RADDR;
          end
        end
        S_RADDR: begin
          if (r_cnt == 3'd0) r_state <= S_ACK2;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        S_ACK2: begin
          if (w_ack_fail) begin
            r_nack  <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt   <= 3'd7;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_cnt == 3'd0) r_state <= S_ACK3;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        S_ACK3: begin
          // Last slot: STOP follows either way, only the flag differs.
          if (w_ack_fail) r_nack <= 1'b1;
          r_state <= S_STOP;
        end
        S_STOP: begin
          r_gap   <= GAP_LOAD;
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_gap == 4'd0) begin
            r_nack  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_wr_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for i2c_wr_arbiter (ACK_CHECK=1, GAP_CYCLES=2). A bench-side slave
// pulls sda low in ACK slots unless a frame is planned to be NACKed.
// -----------------------------------------------------------------------------
module tb_i2c_wr_arbiter;

  localparam int GAP = 2;

  typedef struct packed {
    logic       id;
    logic [1:0] nack_slot;   // 0 = acked frame, 1..3 = ACK slot left high
    logic [4:0] abort_cyc;   // 0 = none, else cycle at which reset hits
    logic [6:0] saddr;
    logic [7:0] raddr;
    logic [7:0] data;
  } exp_t;
  localparam int W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [6:0] req0_saddr = '0, req1_saddr = '0;
  logic [7:0] req0_raddr = '0, req1_raddr = '0;
  logic [7:0] req0_data  = '0, req1_data  = '0;
  logic       req0_ready, req1_ready;
  logic       busy, done, done_id, nack;
  logic [3:0] dbg_state;
  wire        sda;

  logic slave_pull = 1'b0;
  logic next_pull  = 1'b0;
  logic in_frame   = 1'b0;

  pullup (sda);
  assign sda = slave_pull ? 1'b0 : 1'bz;

  i2c_wr_arbiter #(.GAP_CYCLES(GAP), .ACK_CHECK(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_saddr(req0_saddr), .req0_raddr(req0_raddr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_saddr(req1_saddr), .req1_raddr(req1_raddr), .req1_data(req1_data),
    .busy(busy), .done(done), .done_id(done_id), .nack(nack),
    .sda(sda), .dbg_state(dbg_state)
  );

  // Slave pull for the coming cycle is decided by the monitor at the
  // previous negedge and applied just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1 slave_pull = next_pull;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_frame(input logic id, input logic [6:0] sa, input logic [7:0] ra,
                              input logic [7:0] d, input logic [1:0] ns, input logic [4:0] ab);
    exp_t e;
    e.id = id; e.nack_slot = ns; e.abort_cyc = ab;
    e.saddr = sa; e.raddr = ra; e.data = d;
    exp_q.push_back(e);
  endtask

  // Expected wire level at frame cycle t (grant = cycle 0).
  function automatic logic exp_bit(input exp_t e, input int t, input int stop);
    logic [7:0] b;
    if (t >= stop) return 1'b1;
    if (t == 1) return 1'b0;
    if (t >= 2 && t <= 9) begin b = {e.saddr, 1'b0}; return b[9 - t]; end
    if (t == 10) return (e.nack_slot == 2'd1);
    if (t >= 11 && t <= 18) begin b = e.raddr; return b[18 - t]; end
    if (t == 19) return (e.nack_slot == 2'd2);
    if (t >= 20 && t <= 27) begin b = e.data; return b[27 - t]; end
    if (t == 28) return (e.nack_slot == 2'd3);
    return 1'b1;
  endfunction

  function automatic logic pull_at(input exp_t e, input int c, input int stop);
    if (c >= stop) return 1'b0;
    if (c == 10) return (e.nack_slot != 2'd1);
    if (c == 19) return (e.nack_slot != 2'd2);
    if (c == 28) return (e.nack_slot != 2'd3);
    return 1'b0;
  endfunction

  task automatic run_frame(input exp_t e);
    int stop;
    int last;
    stop = (e.nack_slot == 2'd0) ? 29 : 11 + 9 * (int'(e.nack_slot) - 1);
    last = stop + GAP;
    chk("grant_req0", req0_ready, !e.id);
    chk("grant_req1", req1_ready, e.id);
    chk("grant_busy", busy, 0);
    next_pull = 1'b0;
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      chk("sda_bit", sda, exp_bit(e, t, stop));
      chk("busy", busy, 1);
      chk("done", done, (t == stop));
      if (t == stop) begin
        chk("done_id", done_id, e.id);
        chk("nack", nack, (e.nack_slot != 2'd0));
      end
      chk("ready_while_busy", req0_ready | req1_ready, 0);
      next_pull = pull_at(e, t + 1, stop);
      if (e.abort_cyc != 5'd0 && t == int'(e.abort_cyc)) begin
        next_pull = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sda", sda, 1);
        chk("rst_done", done, 0);
        return;
      end
    end
  endtask

  // Monitor: pops an expected frame whenever a ready pulse appears.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (req0_ready || req1_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 1, 0);
        end else begin
          in_frame = 1'b1;
          e = exp_q.pop_front();
          run_frame(e);
          in_frame = 1'b0;
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_sda", sda, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input logic id);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk(id ? "ready1_timeout" : "ready0_timeout", seen, 1);
  endtask

  task automatic send(input logic id, input logic [6:0] sa, input logic [7:0] ra,
                      input logic [7:0] d, input logic [7:0] d_after);
    if (!id) begin
      req0_saddr = sa; req0_raddr = ra; req0_data = d; req0_valid = 1'b1;
    end else begin
      req1_saddr = sa; req1_raddr = ra; req1_data = d; req1_valid = 1'b1;
    end
    wait_ready(id);
    @(posedge clk); #1;
    if (!id) begin
      req0_valid = 1'b0; req0_data = d_after;
    end else begin
      req1_valid = 1'b0; req1_data = d_after;
    end
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !in_frame) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin : main
    // Simultaneous requests from reset: req0 first, req1 at cycle 32.
    expect_frame(1'b0, 7'h2A, 8'h01, 8'h5A, 2'd0, 5'd0);
    expect_frame(1'b1, 7'h51, 8'h80, 8'h0F, 2'd0, 5'd0);
    fork
      send(1'b0, 7'h2A, 8'h01, 8'h5A, 8'h5A);
      send(1'b1, 7'h51, 8'h80, 8'h0F, 8'h0F);
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_busy0", busy, 0);
        chk("rst_done0", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_nack", nack, 0);
        chk("rst_sda0", sda, 1);
        chk("rst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    wait_idle();

    // Fairness: both valid for four frames, grants 0,1,0,1.
    expect_frame(1'b0, 7'h11, 8'h22, 8'h33, 2'd0, 5'd0);
    expect_frame(1'b1, 7'h44, 8'h55, 8'h66, 2'd0, 5'd0);
    expect_frame(1'b0, 7'h77, 8'h88, 8'h99, 2'd0, 5'd0);
    expect_frame(1'b1, 7'h0A, 8'hBB, 8'hCC, 2'd0, 5'd0);
    fork
      begin
        send(1'b0, 7'h11, 8'h22, 8'h33, 8'h33);
        send(1'b0, 7'h77, 8'h88, 8'h99, 8'h99);
      end
      begin
        send(1'b1, 7'h44, 8'h55, 8'h66, 8'h66);
        send(1'b1, 7'h0A, 8'hBB, 8'hCC, 8'hCC);
      end
    join
    wait_idle();

    // Single write: sda 1,0,1,0,0,0,0,0 then 0x12, 0xA5.
    expect_frame(1'b0, 7'h50, 8'h12, 8'hA5, 2'd0, 5'd0);
    send(1'b0, 7'h50, 8'h12, 8'hA5, 8'hA5);
    wait_idle();

    // Payload changes one cycle after ready: 0x3C still goes out.
    expect_frame(1'b0, 7'h1E, 8'h77, 8'h3C, 2'd0, 5'd0);
    send(1'b0, 7'h1E, 8'h77, 8'h3C, 8'hFF);
    wait_idle();

    // NACK at ACK2: STOP at cycle 20 with nack=1, following frame nack=0.
    expect_frame(1'b0, 7'h33, 8'hC3, 8'h99, 2'd2, 5'd0);
    expect_frame(1'b1, 7'h7F, 8'h00, 8'hFF, 2'd0, 5'd0);
    send(1'b0, 7'h33, 8'hC3, 8'h99, 8'h99);
    send(1'b1, 7'h7F, 8'h00, 8'hFF, 8'hFF);
    wait_idle();

    // Reset at cycle 15 of a req1 frame; pending req0 goes first afterwards.
    expect_frame(1'b1, 7'h45, 8'h5A, 8'hC3, 2'd0, 5'd15);
    expect_frame(1'b0, 7'h0B, 8'hE1, 8'h24, 2'd0, 5'd0);
    req1_saddr = 7'h45; req1_raddr = 8'h5A; req1_data = 8'hC3; req1_valid = 1'b1;
    wait_ready(1'b1);
    @(posedge clk); #1;                       // cycle 1
    req1_valid = 1'b0;
    req0_saddr = 7'h0B; req0_raddr = 8'hE1; req0_data = 8'h24; req0_valid = 1'b1;
    repeat (14) begin @(posedge clk); #1; end // cycle 15
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end  // cycle 17
    rst = 1'b0;
    wait_ready(1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_idle();

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
